ram_access_scheduler: RTL and testbench

- Sequences and shares the unified random_access_memory between three requesters: host word port (single block read/write), matrix loader and vector loader.
- Round-robin arbitration; exactly one RAM command in flight.
- Drives the RAM's one-cycle command pulses and address/dimension inputs, then waits a fixed latency and returns completion to the winner.
- Sits between the TTPU control sequencer and the RAM.

---
 rtl/ram_access_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_ram_access_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_scheduler.sv
// Round-robin scheduler sharing one RAM between host word port, matrix loader and vector loader.
// Define RAM_SCHED_BOUNDS_CHECK_EN to also reject accesses that run past MEM_DEPTH at grant.
//   state | meaning
//   IDLE  | arbitrate from pointer; latch winner fields
//   ISSUE | single RAM command pulse
//   WAIT  | down-count RAM latency
//   DONE  | done (+err if rejected) to winner; advance pointer
module ram_access_scheduler #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int DIM_W       = 6,
  parameter int MAX_DIM     = 32,
  parameter int RAM_LATENCY = 2,
  parameter int MEM_DEPTH   = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  input  logic              mat_req,
  input  logic [ADDR_W-1:0] mat_addr,
  input  logic [DIM_W-1:0]  mat_m,
  input  logic [DIM_W-1:0]  mat_n,
  output logic              mat_done,
  input  logic              vec_req,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic [DIM_W-1:0]  vec_len,
  output logic              vec_done,
  output logic              err,
  output logic              busy,
  output logic              ram_write_block,
  output logic              ram_read_block,
  output logic              ram_read_matrix,
  output logic              ram_read_vector,
  output logic [ADDR_W-1:0] ram_address_block,
  output logic [ADDR_W-1:0] ram_address_matrix,
  output logic [ADDR_W-1:0] ram_address_vector,
  output logic [DIM_W-1:0]  ram_matrix_M,
  output logic [DIM_W-1:0]  ram_matrix_N,
  output logic [DIM_W-1:0]  ram_vector_L,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int CNT_W = 4;
  localparam logic [1:0] SRC_HOST = 2'd0;
  localparam logic [1:0] SRC_MAT  = 2'd1;
  localparam logic [1:0] SRC_VEC  = 2'd2;

`ifdef RAM_SCHED_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ptr_q, win_q, gnt_src;
  logic              rej_q, we_q;
  logic              any_req, gnt_reject;
  logic [ADDR_W-1:0] addr_blk_q, addr_mat_q, addr_vec_q;
  logic [DIM_W-1:0]  dim_m_q, dim_n_q, dim_l_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              oob_host, oob_mat, oob_vec;
  logic              bad_m, bad_n, bad_l;
  logic              in_issue, in_done, host_rd_fin;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (32'(d) > 32'(MAX_DIM));
  endfunction

  // Sums are one bit wider than the address so they cannot wrap.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  logic [2*DIM_W-1:0] mat_area;

  assign mat_area = (2*DIM_W)'(mat_m) * (2*DIM_W)'(mat_n);
  assign oob_host = BOUNDS_EN && ({1'b0, host_addr} >= DEPTH);
  assign oob_mat  = BOUNDS_EN && (({1'b0, mat_addr} + (ADDR_W+1)'(mat_area)) > DEPTH);
  assign oob_vec  = BOUNDS_EN && (({1'b0, vec_addr} + (ADDR_W+1)'(vec_len)) > DEPTH);

  assign bad_m   = dim_bad(mat_m);
  assign bad_n   = dim_bad(mat_n);
  assign bad_l   = dim_bad(vec_len);
  assign any_req = host_req | mat_req | vec_req;

  always_comb begin
    gnt_src    = SRC_HOST;
    gnt_reject = 1'b0;
    case (ptr_q)
      SRC_MAT: begin
        if (mat_req)      gnt_src = SRC_MAT;
        else if (vec_req) gnt_src = SRC_VEC;
        else              gnt_src = SRC_HOST;
      end
      SRC_VEC: begin
        if (vec_req)       gnt_src = SRC_VEC;
        else if (host_req) gnt_src = SRC_HOST;
        else               gnt_src = SRC_MAT;
      end
      default: begin
        if (host_req)     gnt_src = SRC_HOST;
        else if (mat_req) gnt_src = SRC_MAT;
        else              gnt_src = SRC_VEC;
      end
    endcase
    case (gnt_src)
      SRC_MAT: gnt_reject = bad_m | bad_n | oob_mat;
      SRC_VEC: gnt_reject = bad_l | oob_vec;
      default: gnt_reject = oob_host;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = gnt_reject ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(RAM_LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= SRC_HOST;
      win_q      <= SRC_HOST;
      rej_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_blk_q <= '0;
      addr_mat_q <= '0;
      addr_vec_q <= '0;
      dim_m_q    <= '0;
      dim_n_q    <= '0;
      dim_l_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && any_req) begin
        win_q <= gnt_src;
        rej_q <= gnt_reject;
        case (gnt_src)
          SRC_MAT: begin
            addr_mat_q <= mat_addr;
            dim_m_q    <= mat_m;
            dim_n_q    <= mat_n;
          end
          SRC_VEC: begin
            addr_vec_q <= vec_addr;
            dim_l_q    <= vec_len;
          end
          default: begin
            addr_blk_q <= host_addr;
            wdata_q    <= host_wdata;
            we_q       <= host_we;
          end
        endcase
      end
      if (in_done) begin
        case (win_q)
          SRC_HOST: ptr_q <= SRC_MAT;
          SRC_MAT:  ptr_q <= SRC_VEC;
          default:  ptr_q <= SRC_HOST;
        endcase
      end
      if (host_rd_fin) rdata_q <= ram_data_out;
    end
  end

  assign in_issue = (state_q == S_ISSUE);
  assign in_done  = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);

  assign ram_write_block = in_issue && (win_q == SRC_HOST) && we_q;
  assign ram_read_block  = in_issue && (win_q == SRC_HOST) && !we_q;
  assign ram_read_matrix = in_issue && (win_q == SRC_MAT);
  assign ram_read_vector = in_issue && (win_q == SRC_VEC);

  assign host_done = in_done && (win_q == SRC_HOST);
  assign mat_done  = in_done && (win_q == SRC_MAT);
  assign vec_done  = in_done && (win_q == SRC_VEC);
  assign err       = in_done && rej_q;

  // Read data is passed straight through with host_done, then held in rdata_q.
  assign host_rd_fin = host_done && !we_q && !rej_q;
  assign host_rdata  = host_rd_fin ? ram_data_out : rdata_q;

  assign ram_address_block  = addr_blk_q;
  assign ram_address_matrix = addr_mat_q;
  assign ram_address_vector = addr_vec_q;
  assign ram_matrix_M       = dim_m_q;
  assign ram_matrix_N       = dim_n_q;
  assign ram_vector_L       = dim_l_q;
  assign ram_data_in        = wdata_q;

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Self-checking bench for ram_access_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level scheduler model and a behavioural RAM.
module tb_ram_access_scheduler;
  localparam int ADDR_W = 20, DATA_W = 16, DIM_W = 6, MAX_DIM = 32, LAT = 2, MEM_DEPTH = 1048576;

  logic clk, rst_n;
  logic host_req, host_we, host_done, mat_req, mat_done, vec_req, vec_done, err, busy;
  logic [ADDR_W-1:0] host_addr, mat_addr, vec_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata, ram_data_in, ram_data_out;
  logic [DIM_W-1:0]  mat_m, mat_n, vec_len;
  logic ram_write_block, ram_read_block, ram_read_matrix, ram_read_vector;
  logic [ADDR_W-1:0] ram_address_block, ram_address_matrix, ram_address_vector;
  logic [DIM_W-1:0]  ram_matrix_M, ram_matrix_N, ram_vector_L;

  ram_access_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_DIM(MAX_DIM),
                         .RAM_LATENCY(LAT), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_done(host_done),
    .mat_req(mat_req), .mat_addr(mat_addr), .mat_m(mat_m), .mat_n(mat_n), .mat_done(mat_done),
    .vec_req(vec_req), .vec_addr(vec_addr), .vec_len(vec_len), .vec_done(vec_done),
    .err(err), .busy(busy),
    .ram_write_block(ram_write_block), .ram_read_block(ram_read_block),
    .ram_read_matrix(ram_read_matrix), .ram_read_vector(ram_read_vector),
    .ram_address_block(ram_address_block), .ram_address_matrix(ram_address_matrix),
    .ram_address_vector(ram_address_vector), .ram_matrix_M(ram_matrix_M),
    .ram_matrix_N(ram_matrix_N), .ram_vector_L(ram_vector_L),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] all_outs;
  assign all_outs = {9'b0, host_rdata, host_done, mat_done, vec_done, err, busy,
                     ram_write_block, ram_read_block, ram_read_matrix, ram_read_vector,
                     ram_address_block, ram_address_matrix, ram_address_vector,
                     ram_matrix_M, ram_matrix_N, ram_vector_L, ram_data_in};

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester side: one request per requester, fields held until its done.
  bit req_on[3];
  bit hold_mode, rand_mode;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr, m_addr, v_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [DIM_W-1:0]  m_m, m_n, v_len;

  // Reference model: one transaction outstanding, predicted by cycle number.
  int k = 0, ptr_m = 0, busy_until = -1, grant_cyc = -1, exp_done_cyc = -1, exp_cmd_cyc = -1, exp_src = 0;
  bit exp_err, exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DIM_W-1:0]  exp_d0, exp_d1;
  logic [DATA_W-1:0] exp_wdata, exp_read_val, rdata_hold;
  logic [DATA_W-1:0] mem_m [int];
  logic [DATA_W-1:0] mem_ram [int];
  int grant_log[$];
  int n_vec_cmd = 0;

  function automatic bit model_reject(int w);
    bit r = 0;
    if (w == 1) r = (m_m == 0 || m_m > MAX_DIM || m_n == 0 || m_n > MAX_DIM);
    if (w == 2) r = (v_len == 0 || v_len > MAX_DIM);
`ifdef RAM_SCHED_BOUNDS_CHECK_EN
    if (w == 0 && longint'(h_addr) >= MEM_DEPTH) r = 1;
    if (w == 1 && longint'(m_addr) + longint'(m_m) * longint'(m_n) > MEM_DEPTH) r = 1;
    if (w == 2 && longint'(v_addr) + longint'(v_len) > MEM_DEPTH) r = 1;
`endif
    return r;
  endfunction

  task automatic drive_inputs();
    host_req = req_on[0]; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
    mat_req = req_on[1]; mat_addr = m_addr; mat_m = m_m; mat_n = m_n;
    vec_req = req_on[2]; vec_addr = v_addr; vec_len = v_len;
  endtask

  task automatic rand_fields(input int i);
    case (i)
      0: begin
        h_we = 1'($urandom_range(0, 1));
        h_addr = ADDR_W'($urandom_range(0, 15));
        h_wdata = DATA_W'($urandom);
      end
      1: begin
        m_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(MEM_DEPTH - int'($urandom_range(1, 1500)))
                                             : ADDR_W'($urandom_range(0, 4095));
        m_m = DIM_W'($urandom_range(0, 34));
        m_n = DIM_W'($urandom_range(0, 34));
      end
      default: begin
        v_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(MEM_DEPTH - int'($urandom_range(1, 40)))
                                             : ADDR_W'($urandom_range(0, 4095));
        v_len = DIM_W'($urandom_range(0, 34));
      end
    endcase
  endtask

  task automatic model_grant();
    int w;
    bit found;
    if (k <= busy_until) return;
    found = 0;
    w = 0;
    for (int j = 0; j < 3; j++)
      if (!found && req_on[(ptr_m + j) % 3]) begin
        w = (ptr_m + j) % 3;
        found = 1;
      end
    if (!found) return;
    grant_log.push_back(w);
    grant_cyc = k;
    exp_src = w;
    exp_err = model_reject(w);
    ptr_m = (w + 1) % 3;
    if (exp_err) begin
      exp_cmd_cyc = -1;
      exp_done_cyc = k + 1;
    end else begin
      exp_cmd_cyc = k + 1;
      exp_done_cyc = k + 2 + LAT;
    end
    busy_until = exp_done_cyc;
    case (w)
      0: begin
        exp_addr = h_addr; exp_we = h_we; exp_wdata = h_wdata;
        if (!exp_err) begin
          if (h_we) mem_m[int'(h_addr)] = h_wdata;
          else exp_read_val = mem_m.exists(int'(h_addr)) ? mem_m[int'(h_addr)] : '0;
        end
      end
      1: begin exp_addr = m_addr; exp_d0 = m_m; exp_d1 = m_n; end
      default: begin exp_addr = v_addr; exp_d0 = v_len; end
    endcase
  endtask

  task automatic eval_cycle();
    logic [8:0] obs, exp;
    logic [DATA_W-1:0] exp_rd;
    bit at_done, at_cmd, rd_fin;
    k++;
    at_done = (k == exp_done_cyc);
    at_cmd  = (k == exp_cmd_cyc);
    exp = {(k > grant_cyc && k <= busy_until),
           at_done && exp_src == 0, at_done && exp_src == 1, at_done && exp_src == 2, at_done && exp_err,
           at_cmd && exp_src == 0 && exp_we, at_cmd && exp_src == 0 && !exp_we,
           at_cmd && exp_src == 1, at_cmd && exp_src == 2};
    obs = {busy, host_done, mat_done, vec_done, err,
           ram_write_block, ram_read_block, ram_read_matrix, ram_read_vector};
    check_eq("pulses", obs, exp);
    rd_fin = at_done && exp_src == 0 && !exp_we && !exp_err;
    exp_rd = rd_fin ? exp_read_val : rdata_hold;
    check_eq("host_rdata", host_rdata, exp_rd);
    if (rd_fin) rdata_hold = exp_read_val;
    if (at_cmd) begin
      case (exp_src)
        0: begin
          check_eq("blk_addr", ram_address_block, exp_addr);
          if (exp_we) check_eq("data_in", ram_data_in, exp_wdata);
        end
        1: begin
          check_eq("mat_addr", ram_address_matrix, exp_addr);
          check_eq("mat_dims", {ram_matrix_M, ram_matrix_N}, {exp_d0, exp_d1});
        end
        default: begin
          check_eq("vec_addr", ram_address_vector, exp_addr);
          check_eq("vec_len", ram_vector_L, exp_d0);
        end
      endcase
    end
    // Behavioural RAM: data is ready well before the done cycle.
    if (ram_write_block) mem_ram[int'(ram_address_block)] = ram_data_in;
    if (ram_read_block)
      ram_data_out = mem_ram.exists(int'(ram_address_block)) ? mem_ram[int'(ram_address_block)] : '0;
    if (ram_read_vector) n_vec_cmd++;
    if (at_done && !hold_mode) req_on[exp_src] = 0;
    if (rand_mode)
      for (int i = 0; i < 3; i++)
        if (!req_on[i] && $urandom_range(0, 3) == 0) begin
          rand_fields(i);
          req_on[i] = 1;
        end
    drive_inputs();
    model_grant();
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((req_on[0] || req_on[1] || req_on[2] || k <= busy_until) && g < 300) begin
      step();
      g++;
    end
    check_eq("drain", 128'(g < 300), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, gsz, nv, g;
    rst_n = 1'b1;
    req_on = '{0, 0, 0};
    hold_mode = 0; rand_mode = 0;
    h_we = 0; h_addr = '0; h_wdata = '0; m_addr = '0; m_m = '0; m_n = '0; v_addr = '0; v_len = '0;
    rdata_hold = '0; exp_read_val = '0; ram_data_out = '0;
    drive_inputs();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outs, '0);
    rst_n = 1'b1;
    eval_cycle();

    // All three held together: order host, mat, vec, host, mat, vec.
    h_we = 1; h_addr = 20'd7; h_wdata = 16'h1234;
    m_addr = 20'h40; m_m = 6'd4; m_n = 6'd4;
    v_addr = 20'h80; v_len = 6'd8;
    req_on = '{1, 1, 1};
    hold_mode = 1;
    base = grant_log.size();
    for (int i = 0; i < 200 && grant_log.size() < base + 6; i++) step();
    hold_mode = 0;
    wait_idle();
    check_eq("rr_count", 128'(grant_log.size() >= base + 6), 128'(1));
    for (int j = 0; j < 6; j++)
      check_eq("rr_order", 128'((grant_log.size() > base + j) ? grant_log[base + j] : 9), 128'(j % 3));

    // Host write then read back.
    h_we = 1; h_addr = 20'd5; h_wdata = 16'hBEEF; req_on[0] = 1;
    wait_idle();
    h_we = 0; req_on[0] = 1;
    wait_idle();
    check_eq("rdata_beef", host_rdata, 16'hBEEF);

    // Minimal matrix load.
    m_addr = '0; m_m = 6'd2; m_n = 6'd2; req_on[1] = 1;
    wait_idle();

    // Illegal vector lengths never reach the RAM.
    nv = n_vec_cmd;
    v_addr = 20'd10; v_len = 6'd0; req_on[2] = 1;
    wait_idle();
    v_len = 6'd33; req_on[2] = 1;
    wait_idle();
    check_eq("vec_no_cmd", 128'(n_vec_cmd - nv), 128'(0));

    // Vectors near the top of memory.
    v_addr = ADDR_W'(1048570); v_len = 6'd8; req_on[2] = 1;
    wait_idle();
    v_addr = ADDR_W'(1048568); v_len = 6'd8; req_on[2] = 1;
    wait_idle();

    // Reset during WAIT of a matrix load with a vector request pending.
    h_we = 0; h_addr = 20'd5; req_on[0] = 1;
    wait_idle();
    m_addr = 20'h100; m_m = 6'd3; m_n = 6'd3; req_on[1] = 1;
    gsz = grant_log.size();
    g = 0;
    while (grant_log.size() == gsz && g < 50) begin step(); g++; end
    v_addr = 20'h200; v_len = 6'd4; req_on[2] = 1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check_eq("reset_async", all_outs, '0);
    busy_until = -1; exp_done_cyc = -1; exp_cmd_cyc = -1; grant_cyc = -1; ptr_m = 0; rdata_hold = '0;
    req_on[1] = 0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gsz = grant_log.size();
    eval_cycle();
    wait_idle();
    check_eq("post_reset_grant", 128'((grant_log.size() > gsz) ? grant_log[gsz] : 9), 128'(2));

    // Random traffic.
    rand_mode = 1;
    repeat (600) step();
    rand_mode = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
